rainbow_stream_gen: RTL and testbench

//  Downstream consumer of the Pixel coordinate counter in the rainbow test path.
//  - Drives the counter's en (pix_en) and samples its X/Y.
//  - Produces an animated rainbow RGB pixel stream over a valid/ready interface

---
 rtl/rainbow_stream_gen.sv | 136 +++++++++++++
 tb/tb_rainbow_stream_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rainbow_stream_gen.sv
// Rainbow test-pattern stream generator.
// Pulls X/Y from the pixel counter and emits animated hue RGB over valid/ready.
module rainbow_stream_gen #(
    parameter int H_ACTIVE   = 1024,
    parameter int V_ACTIVE   = 768,
    parameter int PHASE_STEP = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic        pix_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_rgb,
    output logic        out_sof,
    output logic        out_eol,
    output logic [10:0] phase
);

    localparam logic [11:0] HUE_MOD = 12'd1536;
    localparam logic [9:0]  X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [11:0] STEP    = 12'(PHASE_STEP);

    logic        adv;
    logic [11:0] sum0, sum1, sum2;
    logic [11:0] ph_sum0, ph_sum1;
    logic        cur_sof, cur_eol, frame_end;
    logic [2:0]  seg;
    logic [7:0]  f, nf;
    logic [23:0] rgb;

    logic        s1_valid_q, s1_valid_d;
    logic [10:0] s1_hue_q, s1_hue_d;
    logic        s1_sof_q, s1_sof_d;
    logic        s1_eol_q, s1_eol_d;
    logic        out_valid_q, out_valid_d;
    logic [23:0] out_rgb_q, out_rgb_d;
    logic        out_sof_q, out_sof_d;
    logic        out_eol_q, out_eol_d;
    logic [10:0] phase_q, phase_d;

    // Handshake: the whole pipe advances whenever the output slot frees up.
    always_comb begin
        adv    = !out_valid_q || out_ready;
        pix_en = run && rst_n && adv;
    end

    // S1 arithmetic: hue of the incoming coordinate, flags and phase update.
    always_comb begin
        sum0 = {2'b00, pix_x} + {2'b00, pix_y} + {1'b0, phase_q};
        sum1 = (sum0 >= HUE_MOD) ? sum0 - HUE_MOD : sum0;
        sum2 = (sum1 >= HUE_MOD) ? sum1 - HUE_MOD : sum1;
        cur_sof   = (pix_x == 10'd0) && (pix_y == 10'd0);
        cur_eol   = (pix_x == X_LAST);
        frame_end = cur_eol && (pix_y == Y_LAST);
        ph_sum0 = {1'b0, phase_q} + STEP;
        ph_sum1 = (ph_sum0 >= HUE_MOD) ? ph_sum0 - HUE_MOD : ph_sum0;
    end

    // S2 arithmetic: map the registered hue onto the six colour ramps.
    always_comb begin
        seg = s1_hue_q[10:8];
        f   = s1_hue_q[7:0];
        nf  = 8'hFF - f;
        case (seg)
            3'd0:    rgb = {8'hFF, f, 8'h00};
            3'd1:    rgb = {nf, 8'hFF, 8'h00};
            3'd2:    rgb = {8'h00, 8'hFF, f};
            3'd3:    rgb = {8'h00, nf, 8'hFF};
            3'd4:    rgb = {f, 8'h00, 8'hFF};
            3'd5:    rgb = {8'hFF, 8'h00, nf};
            default: rgb = 24'h000000;
        endcase
    end

    // Next-state: both stages shift together on adv, otherwise hold.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_hue_d    = s1_hue_q;
        s1_sof_d    = s1_sof_q;
        s1_eol_d    = s1_eol_q;
        out_valid_d = out_valid_q;
        out_rgb_d   = out_rgb_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        phase_d     = phase_q;
        if (adv) begin
            out_valid_d = s1_valid_q;
            out_rgb_d   = rgb;
            out_sof_d   = s1_sof_q;
            out_eol_d   = s1_eol_q;
            s1_valid_d  = pix_en;
            s1_hue_d    = sum2[10:0];
            s1_sof_d    = cur_sof;
            s1_eol_d    = cur_eol;
        end
        if (pix_en && frame_end) begin
            phase_d = ph_sum1[10:0];
        end
    end

    // State registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_hue_q    <= '0;
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_rgb_q   <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            phase_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_hue_q    <= s1_hue_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            out_valid_q <= out_valid_d;
            out_rgb_q   <= out_rgb_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            phase_q     <= phase_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_rgb   = out_rgb_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_rainbow_stream_gen.sv
// Bench for rainbow_stream_gen: pixel-counter model, hue reference model,
// scoreboard queue and an output monitor.
module tb_rainbow_stream_gen;

    localparam int H    = 16;
    localparam int V    = 4;
    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        out_ready = 1'b0;
    logic [9:0]  pix_x, pix_y;
    logic        pix_en, out_valid, out_sof, out_eol;
    logic [23:0] out_rgb;
    logic [10:0] phase;

    logic        ld = 1'b0;
    logic [9:0]  ld_x = '0, ld_y = '0;

    int checks = 0;
    int failures = 0;
    int xfers = 0, eols = 0, sofs = 0;
    int mphase = 0;
    logic [25:0] exp_q[$];
    logic        held = 1'b0;
    logic [25:0] held_v = '0;

    rainbow_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .PHASE_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .pix_x(pix_x), .pix_y(pix_y), .pix_en(pix_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rgb(out_rgb), .out_sof(out_sof), .out_eol(out_eol),
        .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] ref_pixel(int x, int y, int ph);
        int h, seg, f, r, g, b;
        h = (x + y + ph) % 1536;
        seg = h / 256;
        f = h % 256;
        case (seg)
            0: begin r = 255;     g = f;       b = 0;       end
            1: begin r = 255 - f; g = 255;     b = 0;       end
            2: begin r = 0;       g = 255;     b = f;       end
            3: begin r = 0;       g = 255 - f; b = 255;     end
            4: begin r = f;       g = 0;       b = 255;     end
            default: begin r = 255; g = 0;     b = 255 - f; end
        endcase
        return {r[7:0], g[7:0], b[7:0], (x == 0 && y == 0), (x == H - 1)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pixel coordinate counter (the upstream block), with a test load port.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_x <= '0;
            pix_y <= '0;
        end else if (ld) begin
            pix_x <= ld_x;
            pix_y <= ld_y;
        end else if (pix_en) begin
            if (int'(pix_x) == H - 1) begin
                pix_x <= '0;
                pix_y <= (int'(pix_y) == V - 1) ? 10'd0 : pix_y + 10'd1;
            end else begin
                pix_x <= pix_x + 10'd1;
            end
        end
    end

    // Scoreboard producer: each sampled coordinate queues its expected pixel.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            mphase = 0;
        end else if (pix_en) begin
            exp_q.push_back(ref_pixel(int'(pix_x), int'(pix_y), mphase));
            if (int'(pix_x) == H - 1 && int'(pix_y) == V - 1)
                mphase = (mphase + STEP) % 1536;
        end
    end

    // Monitor: pops and compares on every accepted transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (held && out_valid)
                check("hold_stable", {6'd0, out_rgb, out_sof, out_eol}, {6'd0, held_v});
            if (out_valid && out_ready) begin
                xfers++;
                if (out_eol) eols++;
                if (out_sof) sofs++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %h expected none", out_rgb);
                end else begin
                    check("pixel", {6'd0, out_rgb, out_sof, out_eol}, {6'd0, exp_q.pop_front()});
                end
            end
            held = out_valid && !out_ready;
            held_v = {out_rgb, out_sof, out_eol};
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] x, input logic [9:0] y);
        ld = 1'b1;
        ld_x = x;
        ld_y = y;
        tick();
        ld = 1'b0;
    endtask

    initial begin
        int base_x, base_e, base_s;
        logic done;
        logic [23:0] r;

        // Reset state
        rst_n = 1'b0;
        run = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", out_valid, 0);
        check("rst_rgb", out_rgb, 0);
        check("rst_sof", out_sof, 0);
        check("rst_eol", out_eol, 0);
        check("rst_phase", phase, 0);
        check("rst_pix_en", pix_en, 0);

        // First pixel latency
        rst_n = 1'b1;
        run = 1'b1;
        tick();
        check("lat_edge1_valid", out_valid, 0);
        tick();
        check("lat_edge2_valid", out_valid, 1);
        check("first_rgb", out_rgb, 24'hFF0000);
        check("first_sof", out_sof, 1);
        check("first_eol", out_eol, 0);
        run = 1'b0;
        repeat (3) tick();

        // Directed hue points
        load(10'd255, 10'd0);
        run = 1'b1;
        tick();
        tick();
        run = 1'b0;
        check("x255_valid", out_valid, 1);
        check("x255_rgb", out_rgb, 24'hFFFF00);
        tick();
        check("x256_valid", out_valid, 1);
        check("x256_rgb", out_rgb, 24'hFFFF00);
        repeat (2) tick();
        load(10'd767, 10'd768);
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        check("wrap_valid", out_valid, 1);
        check("wrap_rgb", out_rgb, 24'hFF0000);
        repeat (2) tick();

        // Back-pressure stall
        load(10'd3, 10'd1);
        run = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        tick();
        r = out_rgb;
        for (int i = 0; i < 5; i++) begin
            check("stall_pix_en", pix_en, 0);
            check("stall_valid", out_valid, 1);
            check("stall_rgb", out_rgb, r);
            if (i < 4) tick();
        end
        out_ready = 1'b1;
        repeat (6) tick();
        run = 1'b0;
        repeat (3) tick();

        // Full frame
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        base_x = xfers;
        base_e = eols;
        base_s = sofs;
        run = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 2000 && !done; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (xfers - base_x == H * V) done = 1'b1;
        end
        check("frame_done", done, 1);
        check("frame_eols", eols - base_e, V);
        check("frame_sofs", sofs - base_s, 1);
        check("frame_phase", phase, STEP);
        check("next_valid", out_valid, 1);
        check("next_rgb", out_rgb, 24'hFF0800);
        check("next_sof", out_sof, 1);

        // Async reset mid-frame, between clock edges
        out_ready = 1'b1;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_phase", phase, 0);
        check("arst_pix_en", pix_en, 0);
        check("arst_rgb", out_rgb, 0);
        #1;
        rst_n = 1'b1;

        // Randomized run / out_ready stream
        for (int i = 0; i < 30000; i++) begin
            run = (i < 15000) ? ~run : ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            if (i % 64 == 0) check("phase_track", phase, mphase);
        end

        // Drain
        run = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
